// File: rtl/uart_cmd_parser_pkg.sv
// uart_cmd_parser_pkg
//   Shared constants and types for the UART command parser slice:
//   default frame parameters, opcode values, parser FSM state encoding
//   and a small opcode decode helper.
package uart_cmd_parser_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF   = 8'hA5;
  localparam logic [7:0] OP_WR           = 8'h57;
  localparam logic [7:0] OP_RD           = 8'h52;
  localparam int         ADDR_BYTES_DEF  = 3;
  localparam int         DATA_BYTES_DEF  = 2;
  localparam int         TIMEOUT_CYC_DEF = 50000;

  typedef enum logic [2:0] {
    S_HUNT,
    S_OP,
    S_ADDR,
    S_DATA,
    S_CHK
  } parser_state_t;

  function automatic logic is_opcode(input logic [7:0] b);
    return (b == OP_WR) || (b == OP_RD);
  endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// uart_cmd_parser_if
//   Valid/ready command bus from the parser to the SDRAM command arbiter.
//   Signals:
//     cmd_valid  command available (driven by master)
//     cmd_ready  downstream accepts command (driven by slave)
//     cmd_write  1 = write, 0 = read
//     cmd_addr   SDRAM word address, ADDR_W bits
//     cmd_wdata  write data, DATA_W bits (0 for reads)
//   master modport: the parser.  slave modport: the consumer.
interface uart_cmd_parser_if
  import uart_cmd_parser_pkg::*;
#(
  parameter int ADDR_W = 8 * ADDR_BYTES_DEF,
  parameter int DATA_W = 8 * DATA_BYTES_DEF
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  modport master (
    output cmd_valid,
    output cmd_write,
    output cmd_addr,
    output cmd_wdata,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_write,
    input  cmd_addr,
    input  cmd_wdata,
    output cmd_ready
  );

endinterface

// File: rtl/uart_cmd_parser_byte_timer.sv
// uart_byte_timer
//   Inter-byte timeout counter.
//   Ports:
//     clk      in  system clock
//     reset_n  in  asynchronous, active-low reset
//     clear    in  restart the count from 0 (has priority)
//     enable   in  count this cycle
//     expire   out combinational pulse when the count reaches TIMEOUT_CYC-1;
//                  the counter restarts from 0 on the same edge
module uart_byte_timer
  import uart_cmd_parser_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CNT_W-1:0] count;

  // A clear in the same cycle suppresses expiry, so a byte arriving on the
  // last allowed cycle is still accepted.
  assign expire = enable && !clear && (count == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear || expire) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
//   Assembles framed host commands received from uart_rx into SDRAM
//   read/write requests.  Frame: SYNC, OP, ADDR (MSB first),
//   DATA (MSB first, writes only), CHK = XOR of OP, ADDR and DATA bytes.
//   Ports:
//     clk           in  system clock
//     reset_n       in  asynchronous, active-low reset
//     rx_done_tick  in  one-cycle strobe: rx_data holds a new byte
//     rx_data       in  received byte
//     cmd_bus       master side of the valid/ready command bus
//     err_chk       out one-cycle pulse: checksum mismatch
//     err_cmd       out one-cycle pulse: unknown opcode
//     err_timeout   out one-cycle pulse: inter-byte timeout
//     err_overrun   out one-cycle pulse: frame dropped, output still occupied
//     err_count     out saturating count of cycles with any error pulse
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         ADDR_BYTES  = ADDR_BYTES_DEF,
  parameter int         DATA_BYTES  = DATA_BYTES_DEF,
  parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      rx_done_tick,
  input  logic [7:0]                rx_data,
  uart_cmd_parser_if.master         cmd_bus,
  output logic                      err_chk,
  output logic                      err_cmd,
  output logic                      err_timeout,
  output logic                      err_overrun,
  output logic [7:0]                err_count
);

  localparam int ADDR_W  = 8 * ADDR_BYTES;
  localparam int DATA_W  = 8 * DATA_BYTES;
  localparam int BCNT_W  = 4;

  parser_state_t     state;
  logic              op_write;
  logic [7:0]        chk;
  logic [BCNT_W-1:0] byte_cnt;
  logic [ADDR_W-1:0] addr_sh;
  logic [DATA_W-1:0] data_sh;

  logic timer_clear;
  logic timer_expire;

  logic set_chk;
  logic set_cmd;
  logic set_overrun;
  logic set_timeout;
  logic commit;
  logic any_err;

  // The timer only runs inside a frame; every received byte restarts it.
  assign timer_clear = rx_done_tick || (state == S_HUNT);

  uart_byte_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .enable  (1'b1),
    .expire  (timer_expire)
  );

  // Frame-level decisions taken on the current byte.  A good checksum
  // either commits (output slot free, or being emptied this cycle) or is
  // dropped as an overrun.
  always_comb begin
    set_chk     = 1'b0;
    set_cmd     = 1'b0;
    set_overrun = 1'b0;
    commit      = 1'b0;
    set_timeout = timer_expire;
    if (rx_done_tick) begin
      if (state == S_OP && !is_opcode(rx_data)) begin
        set_cmd = 1'b1;
      end
      if (state == S_CHK) begin
        if (rx_data != chk) begin
          set_chk = 1'b1;
        end else if (!cmd_bus.cmd_valid || cmd_bus.cmd_ready) begin
          commit = 1'b1;
        end else begin
          set_overrun = 1'b1;
        end
      end
    end
    any_err = set_chk | set_cmd | set_overrun | set_timeout;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= S_HUNT;
      op_write          <= 1'b0;
      chk               <= '0;
      byte_cnt          <= '0;
      addr_sh           <= '0;
      data_sh           <= '0;
      cmd_bus.cmd_valid <= 1'b0;
      cmd_bus.cmd_write <= 1'b0;
      cmd_bus.cmd_addr  <= '0;
      cmd_bus.cmd_wdata <= '0;
      err_chk           <= 1'b0;
      err_cmd           <= 1'b0;
      err_timeout       <= 1'b0;
      err_overrun       <= 1'b0;
      err_count         <= '0;
    end else begin
      err_chk     <= set_chk;
      err_cmd     <= set_cmd;
      err_timeout <= set_timeout;
      err_overrun <= set_overrun;
      if (any_err && err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end

      // A commit in the same cycle as a transfer reloads the slot, so the
      // commit assignment below must come after the clear.
      if (cmd_bus.cmd_valid && cmd_bus.cmd_ready) begin
        cmd_bus.cmd_valid <= 1'b0;
      end
      if (commit) begin
        cmd_bus.cmd_valid <= 1'b1;
        cmd_bus.cmd_write <= op_write;
        cmd_bus.cmd_addr  <= addr_sh;
        cmd_bus.cmd_wdata <= op_write ? data_sh : '0;
      end

      if (rx_done_tick) begin
        case (state)
          S_HUNT: begin
            if (rx_data == SYNC_BYTE) begin
              state <= S_OP;
            end
          end
          S_OP: begin
            if (is_opcode(rx_data)) begin
              op_write <= (rx_data == OP_WR);
              chk      <= rx_data;
              byte_cnt <= '0;
              state    <= S_ADDR;
            end else begin
              state <= S_HUNT;
            end
          end
          S_ADDR: begin
            addr_sh <= ADDR_W'({addr_sh, rx_data});
            chk     <= chk ^ rx_data;
            if (byte_cnt == BCNT_W'(ADDR_BYTES - 1)) begin
              byte_cnt <= '0;
              state    <= op_write ? S_DATA : S_CHK;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
          S_DATA: begin
            data_sh <= DATA_W'({data_sh, rx_data});
            chk     <= chk ^ rx_data;
            if (byte_cnt == BCNT_W'(DATA_BYTES - 1)) begin
              byte_cnt <= '0;
              state    <= S_CHK;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
          S_CHK: begin
            state <= S_HUNT;
          end
          default: begin
            state <= S_HUNT;
          end
        endcase
      end else if (timer_expire) begin
        state <= S_HUNT;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb_uart_cmd_parser
//   Scoreboard bench for uart_cmd_parser.  Stimulus pushes expected
//   commands and error pulses into queues; a monitor on the falling clock
//   edge pops and compares whenever the DUT transfers a command or raises
//   an error pulse.
module tb_uart_cmd_parser;
  import uart_cmd_parser_pkg::*;

  localparam int TB_TIMEOUT = 64;

  localparam logic [3:0] E_CHK = 4'b1000;
  localparam logic [3:0] E_CMD = 4'b0100;
  localparam logic [3:0] E_TO  = 4'b0010;
  localparam logic [3:0] E_OV  = 4'b0001;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    logic        write;
    logic [23:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       err_chk;
  logic       err_cmd;
  logic       err_timeout;
  logic       err_overrun;
  logic [7:0] err_count;

  uart_cmd_parser_if #(.ADDR_W(24), .DATA_W(16)) cmd_bus ();

  uart_cmd_parser #(
    .SYNC_BYTE   (8'hA5),
    .ADDR_BYTES  (3),
    .DATA_BYTES  (2),
    .TIMEOUT_CYC (TB_TIMEOUT)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .cmd_bus      (cmd_bus),
    .err_chk      (err_chk),
    .err_cmd      (err_cmd),
    .err_timeout  (err_timeout),
    .err_overrun  (err_overrun),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  cmd_t       cmd_q[$];
  logic [3:0] err_q[$];
  int         model_cnt = 0;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_done_tick = 1'b1;
    rx_data      = b;
    @(posedge clk);
    #1;
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
  endtask

  task automatic apply_stimulus(input byte_q_t bytes, input int gap);
    foreach (bytes[i]) begin
      send_byte(bytes[i]);
      idle(gap);
    end
  endtask

  task automatic expect_cmd(input logic w, input logic [23:0] a, input logic [15:0] d);
    cmd_t c;
    c.write = w;
    c.addr  = a;
    c.wdata = d;
    cmd_q.push_back(c);
  endtask

  // Monitor: every transfer and every error pulse is matched against the queues.
  always @(negedge clk) begin
    logic [3:0] errs;
    cmd_t       e;
    if (!reset_n) begin
      model_cnt = 0;
    end else begin
      if (cmd_bus.cmd_valid && cmd_bus.cmd_ready) begin
        if (cmd_q.size() == 0) begin
          check_output("unexpected_cmd_valid", 64'(cmd_bus.cmd_valid), 64'd0);
        end else begin
          e = cmd_q.pop_front();
          check_output("cmd_payload",
                       64'({cmd_bus.cmd_write, cmd_bus.cmd_addr, cmd_bus.cmd_wdata}),
                       64'({e.write, e.addr, e.wdata}));
        end
      end
      errs = {err_chk, err_cmd, err_timeout, err_overrun};
      if (errs != 4'b0000) begin
        if (err_q.size() == 0) begin
          check_output("unexpected_err", 64'(errs), 64'd0);
        end else begin
          check_output("err_kind", 64'(errs), 64'(err_q.pop_front()));
        end
        if (model_cnt != 255) model_cnt++;
        check_output("err_count", 64'(err_count), 64'(model_cnt));
      end
    end
  end

  initial begin
    byte_q_t f;
    reset_n           = 1'b0;
    rx_done_tick      = 1'b0;
    rx_data           = 8'h00;
    cmd_bus.cmd_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_output("reset_outputs",
                 64'({cmd_bus.cmd_valid, cmd_bus.cmd_write, cmd_bus.cmd_addr,
                      cmd_bus.cmd_wdata, err_chk, err_cmd, err_timeout,
                      err_overrun, err_count}), 64'd0);
    reset_n = 1'b1;
    idle(2);

    // Write frame; checksum 57^01^23^45^BE^EF = 61.
    $display("[TB] write frame");
    expect_cmd(1'b1, 24'h012345, 16'hBEEF);
    f = '{8'hA5, 8'h57, 8'h01, 8'h23, 8'h45, 8'hBE, 8'hEF, 8'h61};
    apply_stimulus(f, 0);
    idle(3);

    // Read frame; checksum 52^00^00^10 = 42.
    $display("[TB] read frame");
    expect_cmd(1'b0, 24'h000010, 16'h0000);
    f = '{8'hA5, 8'h52, 8'h00, 8'h00, 8'h10, 8'h42};
    apply_stimulus(f, 1);
    idle(3);

    // Bad checksum, then the good frame again.
    $display("[TB] bad checksum");
    err_q.push_back(E_CHK);
    f = '{8'hA5, 8'h57, 8'h01, 8'h23, 8'h45, 8'hBE, 8'hEF, 8'h00};
    apply_stimulus(f, 0);
    idle(3);
    expect_cmd(1'b1, 24'h012345, 16'hBEEF);
    f = '{8'hA5, 8'h57, 8'h01, 8'h23, 8'h45, 8'hBE, 8'hEF, 8'h61};
    apply_stimulus(f, 0);
    idle(3);

    // Garbage ignored, unknown opcode flagged.
    $display("[TB] garbage and bad opcode");
    err_q.push_back(E_CMD);
    f = '{8'h11, 8'h22, 8'hA5, 8'h33};
    apply_stimulus(f, 0);
    idle(3);

    // Inter-byte timeout, then a full read frame (chk 52^12^34^56 = 22).
    $display("[TB] timeout");
    err_q.push_back(E_TO);
    f = '{8'hA5, 8'h57, 8'h01};
    apply_stimulus(f, 0);
    idle(TB_TIMEOUT + 5);
    expect_cmd(1'b0, 24'h123456, 16'h0000);
    f = '{8'hA5, 8'h52, 8'h12, 8'h34, 8'h56, 8'h22};
    apply_stimulus(f, 0);
    idle(3);

    // Last byte on the final allowed cycle still counts (chk 57^01^02 = 54).
    $display("[TB] timeout boundary");
    expect_cmd(1'b1, 24'h000001, 16'h0002);
    f = '{8'hA5, 8'h57, 8'h00, 8'h00, 8'h01, 8'h00, 8'h02};
    apply_stimulus(f, 0);
    idle(TB_TIMEOUT - 1);
    send_byte(8'h54);
    idle(3);

    // Sync value inside a frame is plain data (chk 52^A5 = F7).
    $display("[TB] sync byte as address");
    expect_cmd(1'b0, 24'hA50000, 16'h0000);
    f = '{8'hA5, 8'h52, 8'hA5, 8'h00, 8'h00, 8'hF7};
    apply_stimulus(f, 0);
    idle(3);

    // Back-pressure: first frame held, second dropped (chk DB and 72).
    $display("[TB] back-pressure and overrun");
    cmd_bus.cmd_ready = 1'b0;
    expect_cmd(1'b1, 24'h0000AA, 16'h1234);
    f = '{8'hA5, 8'h57, 8'h00, 8'h00, 8'hAA, 8'h12, 8'h34, 8'hDB};
    apply_stimulus(f, 0);
    idle(2);
    err_q.push_back(E_OV);
    f = '{8'hA5, 8'h52, 8'h00, 8'h00, 8'h20, 8'h72};
    apply_stimulus(f, 0);
    idle(2);
    check_output("held_payload",
                 64'({cmd_bus.cmd_valid, cmd_bus.cmd_write, cmd_bus.cmd_addr, cmd_bus.cmd_wdata}),
                 64'({1'b1, 1'b1, 24'h0000AA, 16'h1234}));
    cmd_bus.cmd_ready = 1'b1;
    idle(1);
    check_output("valid_drop_after_transfer", 64'(cmd_bus.cmd_valid), 64'd0);
    idle(2);

    // Reset mid-frame with a command pending.
    $display("[TB] reset mid-frame");
    cmd_bus.cmd_ready = 1'b0;
    f = '{8'hA5, 8'h52, 8'h00, 8'h00, 8'h20, 8'h72};
    apply_stimulus(f, 0);
    idle(1);
    check_output("pending_before_reset", 64'(cmd_bus.cmd_valid), 64'd1);
    f = '{8'hA5, 8'h57, 8'h01};
    apply_stimulus(f, 0);
    reset_n = 1'b0;
    #1;
    check_output("async_reset_outputs",
                 64'({cmd_bus.cmd_valid, cmd_bus.cmd_write, cmd_bus.cmd_addr,
                      cmd_bus.cmd_wdata, err_chk, err_cmd, err_timeout,
                      err_overrun, err_count}), 64'd0);
    cmd_q.delete();
    idle(2);
    reset_n           = 1'b1;
    cmd_bus.cmd_ready = 1'b1;
    idle(1);
    expect_cmd(1'b0, 24'h000010, 16'h0000);
    f = '{8'hA5, 8'h52, 8'h00, 8'h00, 8'h10, 8'h42};
    apply_stimulus(f, 0);
    idle(3);

    // Error counter saturation.
    $display("[TB] error counter saturation");
    for (int i = 0; i < 260; i++) begin
      err_q.push_back(E_CMD);
      f = '{8'hA5, 8'h33};
      apply_stimulus(f, 1);
    end
    idle(3);
    check_output("err_count_saturated", 64'(err_count), 64'hFF);

    idle(5);
    check_output("cmd_queue_drained", 64'(cmd_q.size()), 64'd0);
    check_output("err_queue_drained", 64'(err_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
